uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter Clk_FreqHz_g, default 100000000, SHALL be the clock frequency in Hz.
REQ-002 Parameter BaudRate_g, default 115200, SHALL be the line baud rate; Div = floor(Clk_FreqHz_g/BaudRate_g), Div>=2.
REQ-003 Port Clk  input  1  SHALL be the single clock; all logic on rising edge.
REQ-004 Port Rst  input  1  SHALL be the reset, synchronous, active-high.
REQ-005 Ports Req0_Valid/Req1_Valid  input  1  SHALL flag a byte offered by requester n.
REQ-006 Ports Req0_Data/Req1_Data  input  8  SHALL carry the offered byte.
REQ-007 Ports Req0_Last/Req1_Last  input  1  SHALL mark the final byte of a requester packet.
REQ-008 Ports Req0_Ready/Req1_Ready  output  1  SHALL indicate byte acceptance; transfer = Valid&&Ready same cycle.
REQ-009 Port Uart_Tx  output  1  SHALL be the serial line, idle high.
REQ-010 Port Busy  output  1  SHALL be high whenever state is not IDLE.
REQ-011 Port Grant  output  1  SHALL hold the index of the last accepted requester.

Function
REQ-012 FSM states IDLE, START, DATA, PARITY (macro only), STOP SHALL be implemented.
REQ-013 In IDLE, Reqn_Ready SHALL be high only for the selected requester; at most one Ready high per cycle; both low outside IDLE.
REQ-014 Selection: if locked, only the lock owner is eligible; else if one Valid, that one; if both Valid, the requester not granted last (round-robin).
REQ-015 Ready SHALL depend combinationally on state, lock, pointer and Valids only, never on Data.
REQ-016 On transfer: latch Data, set Grant=n, move to START; Uart_Tx SHALL go low the cycle after transfer.
REQ-017 Accepting a byte with Last=0 SHALL lock to that requester; accepting Last=1 SHALL clear the lock.
REQ-018 Each of START, each DATA bit, PARITY, STOP SHALL last exactly Div cycles via a baud counter reloaded on every bit boundary.
REQ-019 DATA SHALL shift out 8 bits LSB first; STOP drives Uart_Tx=1; after STOP return to IDLE.
REQ-020 Frame SHALL occupy 10*Div cycles (11*Div with parity); minimum 1 IDLE cycle between frames, so max throughput is one byte per 10*Div+1 cycles.
REQ-021 Valid without transfer (e.g. during Busy) SHALL have no effect; requester must hold Valid/Data/Last until Ready.
REQ-022 Locked owner deasserting Valid SHALL keep the lock; the other requester stays blocked until owner sends Last=1.

Reset
REQ-023 On a clock edge with Rst=1: state=IDLE, Uart_Tx=1, Busy=0, Grant=0, lock cleared, round-robin pointer favours Req0, baud and bit counters=0.
REQ-024 While Rst=1 both Ready outputs SHALL be 0.
REQ-025 Rst mid-frame SHALL abort the frame; the truncated byte is not retransmitted; Uart_Tx=1 from the cycle after the reset edge.

Configuration
REQ-026 Macro UART_TX_ARBITER_PARITY_EN defined: PARITY state SHALL insert an even-parity bit (XOR of 8 data bits) between bit 7 and STOP.
REQ-027 Macro undefined: PARITY state and logic SHALL be absent; STOP follows bit 7 directly.

Verification (Clk_FreqHz_g=1000000, BaudRate_g=100000, Div=10)
REQ-028 Req0 0x55 Last=1, Req1 idle -> Req0_Ready 1-cycle pulse; Uart_Tx: 10 low, then 1,0,1,0,1,0,1,0 each 10 cycles, 10 high; Busy high 100 cycles; Grant=0.
REQ-029 Both Valid constantly, Req0=0xA0, Req1=0x0B, Last=1 -> frames alternate 0xA0,0x0B,0xA0,...; Grant toggles; gap between frames exactly 1 cycle.
REQ-030 Req0 packet 0x01,0x02,0x03 (Last=0,0,1), Req1 0xFF Valid throughout -> order 0x01,0x02,0x03,0xFF; Req1_Ready stays 0 until lock clears.
REQ-031 Rst pulsed 1 cycle during data bit 3 of Req1 frame, both Valid held -> Uart_Tx=1, Busy=0 next cycle; first frame after reset is Req0's.
REQ-032 Macro defined, byte 0x07 -> parity bit 1, frame 110 cycles; macro undefined -> no parity bit, frame 100 cycles.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter with packet lock driving an 8N1 UART transmitter.
// Define UART_TX_ARBITER_PARITY_EN to insert an even-parity bit between data bit 7 and stop.
module uart_tx_arbiter #(
  parameter int Clk_FreqHz_g = 100000000,
  parameter int BaudRate_g   = 115200
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Req0_Valid,
  input  logic [7:0] Req0_Data,
  input  logic       Req0_Last,
  output logic       Req0_Ready,
  input  logic       Req1_Valid,
  input  logic [7:0] Req1_Data,
  input  logic       Req1_Last,
  output logic       Req1_Ready,
  output logic       Uart_Tx,
  output logic       Busy,
  output logic       Grant
);

  localparam int DIV = Clk_FreqHz_g / BaudRate_g;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] BAUD_MAX = CW'(DIV - 1);

`ifdef UART_TX_ARBITER_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t          state_q, state_d;
  logic [CW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            grant_q, grant_d;
  logic            lock_q, lock_d;
  logic            rr_q, rr_d;
`ifdef UART_TX_ARBITER_PARITY_EN
  logic            par_q, par_d;
`endif

  logic            sel, sel_vld, xfer, baud_end;
  logic [7:0]      sel_data;
  logic            sel_last;

  // While locked only the owner (last granted requester) may be served.
  always_comb begin
    sel     = rr_q;
    sel_vld = 1'b0;
    if (lock_q) begin
      sel     = grant_q;
      sel_vld = grant_q ? Req1_Valid : Req0_Valid;
    end else if (Req0_Valid && Req1_Valid) begin
      sel     = rr_q;
      sel_vld = 1'b1;
    end else if (Req0_Valid) begin
      sel     = 1'b0;
      sel_vld = 1'b1;
    end else if (Req1_Valid) begin
      sel     = 1'b1;
      sel_vld = 1'b1;
    end
  end

  assign Req0_Ready = (state_q == S_IDLE) && !Rst && sel_vld && !sel;
  assign Req1_Ready = (state_q == S_IDLE) && !Rst && sel_vld && sel;
  assign xfer       = Req0_Ready || Req1_Ready;
  assign sel_data   = sel ? Req1_Data : Req0_Data;
  assign sel_last   = sel ? Req1_Last : Req0_Last;
  assign baud_end   = (baud_q == BAUD_MAX);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    grant_d = grant_q;
    lock_d  = lock_q;
    rr_d    = rr_q;
`ifdef UART_TX_ARBITER_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          state_d = S_START;
          baud_d  = '0;
          tx_d    = 1'b0;
          shreg_d = sel_data;
          grant_d = sel;
          rr_d    = !sel;
          lock_d  = !sel_last;
`ifdef UART_TX_ARBITER_PARITY_EN
          par_d   = ^sel_data;
`endif
        end
      end
      S_START: begin
        if (baud_end) begin
          state_d = S_DATA;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shreg_q[0];
        end else begin
          baud_d  = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_ARBITER_PARITY_EN
            state_d = S_PARITY;
            tx_d    = par_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shreg_d = shreg_q >> 1;
            tx_d    = shreg_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`ifdef UART_TX_ARBITER_PARITY_EN
      S_PARITY: begin
        if (baud_end) begin
          state_d = S_STOP;
          baud_d  = '0;
          tx_d    = 1'b1;
        end else begin
          baud_d  = baud_q + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (baud_end) begin
          state_d = S_IDLE;
          baud_d  = '0;
        end else begin
          baud_d  = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      grant_q <= 1'b0;
      lock_q  <= 1'b0;
      rr_q    <= 1'b0;
`ifdef UART_TX_ARBITER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      grant_q <= grant_d;
      lock_q  <= lock_d;
      rr_q    <= rr_d;
`ifdef UART_TX_ARBITER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign Uart_Tx = tx_q;
  assign Busy    = busy_q;
  assign Grant   = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: arbitration rules predicted per cycle, serial line decoded and compared.
module tb_uart_tx_arbiter;
  localparam int CLK_HZ = 1000000;
  localparam int BAUD   = 100000;
  localparam int DIV    = CLK_HZ / BAUD;
`ifdef UART_TX_ARBITER_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * DIV;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       Req0_Valid = 1'b1, Req0_Last = 1'b1, Req0_Ready;
  logic [7:0] Req0_Data = 8'h3C;
  logic       Req1_Valid = 1'b0, Req1_Last = 1'b1, Req1_Ready;
  logic [7:0] Req1_Data = 8'h00;
  logic       Uart_Tx, Busy, Grant;

  uart_tx_arbiter #(.Clk_FreqHz_g(CLK_HZ), .BaudRate_g(BAUD)) dut (
    .Clk(Clk), .Rst(Rst),
    .Req0_Valid(Req0_Valid), .Req0_Data(Req0_Data), .Req0_Last(Req0_Last), .Req0_Ready(Req0_Ready),
    .Req1_Valid(Req1_Valid), .Req1_Data(Req1_Data), .Req1_Last(Req1_Last), .Req1_Ready(Req1_Ready),
    .Uart_Tx(Uart_Tx), .Busy(Busy), .Grant(Grant)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Reference model state
  bit         model_ok = 0;
  bit         lock_m = 0, owner_m = 0, rr_m = 0, grant_m = 0;
  int         e_last = 0;
  logic [8:0] q0[$], q1[$];
  logic [7:0] exp_q[$];
  bit         log_req[$];
  logic [7:0] log_dat[$];
  int         log_cyc[$];
  int         gap0 = 0, gap1 = 0, gap_max = 0;
  int         rdy0_cnt = 0, rdy1_cnt = 0, busy_cnt = 0;

  function automatic logic wave(input logic [7:0] b, input int i);
    int s;
    s = i / DIV;
    if (s == 0) return 1'b0;
    if (s <= 8) return b[s-1];
`ifdef UART_TX_ARBITER_PARITY_EN
    if (s == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic step();
    bit         a0, a1, rst_now, free, esel, evld, n, l;
    logic [7:0] d;
    @(negedge Clk);
    rst_now = Rst;
    a0 = Req0_Valid && Req0_Ready;
    a1 = Req1_Valid && Req1_Ready;
    if (Req0_Ready) rdy0_cnt++;
    if (Req1_Ready) rdy1_cnt++;
    if (Busy) busy_cnt++;
    free = model_ok && (cyc >= e_last + FRAME);
    if (rst_now || !free) begin
      chk("ready_low", 32'({Req1_Ready, Req0_Ready}), 32'd0);
    end else begin
      evld = 0;
      esel = rr_m;
      if (lock_m) begin
        esel = owner_m;
        evld = owner_m ? Req1_Valid : Req0_Valid;
      end else if (Req0_Valid && Req1_Valid) begin
        esel = rr_m;
        evld = 1;
      end else if (Req0_Valid) begin
        esel = 0;
        evld = 1;
      end else if (Req1_Valid) begin
        esel = 1;
        evld = 1;
      end
      chk("arb_accept", 32'({a1, a0}), evld ? (esel ? 32'd2 : 32'd1) : 32'd0);
      chk("one_ready", 32'(Req0_Ready & Req1_Ready), 32'd0);
    end
    if (model_ok)
      chk("busy", 32'(Busy), 32'(cyc >= e_last && cyc < e_last + FRAME));
    if (a0 || a1) begin
      n = a1;
      d = n ? Req1_Data : Req0_Data;
      l = n ? Req1_Last : Req0_Last;
      exp_q.push_back(d);
      log_req.push_back(n);
      log_dat.push_back(d);
      log_cyc.push_back(cyc + 1);
      e_last  = cyc + 1;
      grant_m = n;
      owner_m = n;
      rr_m    = !n;
      lock_m  = !l;
    end
    @(posedge Clk);
    #1;
    if (rst_now) begin
      model_ok = 1;
      lock_m = 0; rr_m = 0; grant_m = 0; owner_m = 0;
      e_last = cyc - FRAME;
      exp_q.delete();
    end
    if (model_ok) chk("grant", 32'(Grant), 32'(grant_m));
    if (a0 && !rst_now) begin
      void'(q0.pop_front());
      Req0_Valid = 1'b0;
      gap0 = int'($urandom_range(gap_max, 0));
    end
    if (a1 && !rst_now) begin
      void'(q1.pop_front());
      Req1_Valid = 1'b0;
      gap1 = int'($urandom_range(gap_max, 0));
    end
    if (!Req0_Valid && q0.size() > 0) begin
      if (gap0 > 0) gap0--;
      else begin Req0_Valid = 1'b1; {Req0_Last, Req0_Data} = q0[0]; end
    end
    if (!Req1_Valid && q1.size() > 0) begin
      if (gap1 > 0) gap1--;
      else begin Req1_Valid = 1'b1; {Req1_Last, Req1_Data} = q1[0]; end
    end
    if (!Req0_Valid) Req0_Data = 8'($urandom);
    if (!Req1_Valid) Req1_Data = 8'($urandom);
  endtask

  // Serial line monitor: decodes each frame and compares it with the scoreboard head
  initial begin
    bit         act;
    int         idx, bad;
    logic [7:0] eb;
    act = 0; idx = 0; bad = 0; eb = 8'h00;
    forever begin
      @(negedge Clk);
      if (Rst !== 1'b0 || !model_ok) begin
        act = 0;
      end else begin
        if (!act && Uart_Tx === 1'b0) begin
          act = 1; idx = 0; bad = 0;
          chk("start_latency", 32'(cyc), 32'(e_last));
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_frame at cycle %0d: got a start bit, expected no frame", cyc);
            eb = 8'h00;
          end else begin
            eb = exp_q.pop_front();
          end
        end
        if (act) begin
          if (Uart_Tx !== wave(eb, idx)) bad++;
          idx++;
          if (idx == FRAME) begin
            chk("frame_wave", 32'(bad), 32'd0);
            act = 0;
          end
        end
      end
    end
  end

  task automatic do_reset();
    Rst = 1'b1;
    step();
    Rst = 1'b0;
  endtask

  task automatic run_idle(input string nm, input int budget);
    int k;
    k = 0;
    while ((q0.size() > 0 || q1.size() > 0 || Req0_Valid || Req1_Valid || cyc < e_last + FRAME + 2)
           && k < budget) begin
      step();
      k++;
    end
    chk(nm, 32'(k < budget), 32'd1);
  endtask

  task automatic clear_logs();
    log_req.delete(); log_dat.delete(); log_cyc.delete();
    rdy0_cnt = 0; rdy1_cnt = 0; busy_cnt = 0;
  endtask

  initial begin
    int k;
    logic [7:0] d;
    // Reset with Req0 offering a byte: neither Ready may rise
    for (int i = 0; i < 3; i++) step();
    Rst = 1'b0;
    Req0_Valid = 1'b0;
    chk("rst_tx", 32'(Uart_Tx), 32'd1);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_grant", 32'(Grant), 32'd0);

    // Single byte 0x55 from Req0
    clear_logs();
    q0.push_back({1'b1, 8'h55});
    run_idle("single_timeout", 3 * FRAME);
    chk("single_ready_pulses", 32'(rdy0_cnt), 32'd1);
    chk("single_busy_cycles", 32'(busy_cnt), 32'(FRAME));
    chk("single_count", 32'(log_dat.size()), 32'd1);
    if (log_dat.size() > 0) chk("single_data", 32'(log_dat[0]), 32'h55);

    // Byte 0x07 from Req1 (parity bit 1 when enabled)
    clear_logs();
    q1.push_back({1'b1, 8'h07});
    run_idle("byte07_timeout", 3 * FRAME);
    chk("byte07_busy_cycles", 32'(busy_cnt), 32'(FRAME));

    // Both requesters always valid: strict alternation, one idle cycle between frames
    do_reset();
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      q0.push_back({1'b1, 8'hA0});
      q1.push_back({1'b1, 8'h0B});
    end
    run_idle("alt_timeout", 10 * (FRAME + 1));
    chk("alt_count", 32'(log_dat.size()), 32'd8);
    for (int i = 0; i < log_dat.size(); i++) begin
      chk("alt_data", 32'(log_dat[i]), (i % 2 == 0) ? 32'hA0 : 32'h0B);
      if (i > 0) chk("alt_gap", 32'(log_cyc[i] - log_cyc[i-1]), 32'(FRAME + 1));
    end

    // Locked packet from Req0 with Req1 waiting throughout
    do_reset();
    clear_logs();
    q0.push_back({1'b0, 8'h01});
    q0.push_back({1'b0, 8'h02});
    q0.push_back({1'b1, 8'h03});
    q1.push_back({1'b1, 8'hFF});
    run_idle("lock_timeout", 6 * (FRAME + 1));
    chk("lock_count", 32'(log_dat.size()), 32'd4);
    if (log_dat.size() == 4) begin
      chk("lock_order0", 32'(log_dat[0]), 32'h01);
      chk("lock_order1", 32'(log_dat[1]), 32'h02);
      chk("lock_order2", 32'(log_dat[2]), 32'h03);
      chk("lock_order3", 32'(log_dat[3]), 32'hFF);
    end
    chk("lock_req1_ready_pulses", 32'(rdy1_cnt), 32'd1);

    // Reset during data bit 3 of a Req1 frame
    do_reset();
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      q0.push_back({1'b1, 8'($urandom)});
      q1.push_back({1'b1, 8'($urandom)});
    end
    k = 0;
    while (!(grant_m && model_ok && cyc == e_last + 4 * DIV + 5) && k < 4 * (FRAME + 1)) begin
      step();
      k++;
    end
    chk("bit3_reached", 32'(k < 4 * (FRAME + 1)), 32'd1);
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    chk("abort_tx", 32'(Uart_Tx), 32'd1);
    chk("abort_busy", 32'(Busy), 32'd0);
    clear_logs();
    run_idle("abort_timeout", 10 * (FRAME + 1));
    chk("abort_some_frames", 32'(log_req.size() > 0), 32'd1);
    if (log_req.size() > 0) chk("abort_first_req0", 32'(log_req[0]), 32'd0);

    // Randomized packets, random gaps, random lock usage
    do_reset();
    clear_logs();
    gap_max = 25;
    for (int i = 0; i < 12; i++) begin
      d = 8'($urandom);
      q0.push_back({(i == 11) ? 1'b1 : 1'($urandom_range(1, 0)), d});
      d = 8'($urandom);
      q1.push_back({(i == 11) ? 1'b1 : 1'($urandom_range(1, 0)), d});
    end
    run_idle("rand_timeout", 30 * (FRAME + 1) + 1000);
    chk("rand_count", 32'(log_dat.size()), 32'd24);
    chk("rand_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time limit reached, expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end
endmodule
